adder_tree: RTL and testbench

// - Pipelined binary reduction tree summing NUM_IN_WORDS packed words, word i weighted by 2^(i*SHIFT_DIST).
// - Core summation engine of LUT-based multipliers: partial products in, full product out.
// - Carries one side-band bit (extra_bit) through the same pipeline for downstream correction logic.

---
 rtl/adder_tree.sv | 132 +++++++++++++
 tb/tb_adder_tree.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree.sv
// adder_tree: pipelined binary reduction of NUM_IN_WORDS words, word i weighted by 2^(i*SHIFT_DIST).
// Define ADDER_TREE_CE_EN to add the `ena` clock-enable port gating every pipeline register.
module adder_tree #(
  parameter int NUM_IN_WORDS     = 8,
  parameter int BITS_PER_IN_WORD = 16,
  parameter int OUT_BITS         = 32,
  parameter int SIGN_EXT         = 0,
  parameter int REGISTER_OUTPUT  = 1,
  parameter int REGISTER_MIDDLE  = 1,
  parameter int SHIFT_DIST       = 1,
  parameter int EXTRA_BIT_USED   = 0
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
`ifdef ADDER_TREE_CE_EN
  input  logic                                       ena,
`endif
  input  logic [NUM_IN_WORDS*BITS_PER_IN_WORD-1:0]   in_words,
  input  logic                                       extra_bit_in,
  output logic                                       extra_bit_out,
  output logic [OUT_BITS-1:0]                        out
);

  localparam int N       = NUM_IN_WORDS;
  localparam int W       = BITS_PER_IN_WORD;
  localparam int NL      = $clog2(N);
  // Wide enough for the exact sum of every term plus a sign bit, and never narrower than out
  localparam int EXACT_W = W + SHIFT_DIST * (N - 1) + NL + 1;
  localparam int TW      = (EXACT_W > OUT_BITS) ? EXACT_W : OUT_BITS;
  localparam int LAT     = ((REGISTER_MIDDLE != 0) ? NL : 0) + ((REGISTER_OUTPUT != 0) ? 1 : 0);

  function automatic int terms_at(input int k);
    return (N + (1 << k) - 1) >> k;
  endfunction

  logic ce;
`ifdef ADDER_TREE_CE_EN
  assign ce = ena;
`else
  assign ce = 1'b1;
`endif

  logic [N-1:0][TW-1:0] terms0;
  logic [W-1:0]         wd;
  logic                 fill;

  always_comb begin
    terms0 = '0;
    wd     = '0;
    fill   = 1'b0;
    for (int i = 0; i < N; i++) begin
      wd        = in_words[i*W +: W];
      fill      = (SIGN_EXT != 0) && wd[W-1];
      terms0[i] = {{(TW-W){fill}}, wd};
    end
  end

  for (genvar k = 0; k < NL; k++) begin : g_lyr
    localparam int NI = terms_at(k);
    localparam int NO = terms_at(k + 1);
    localparam int SH = SHIFT_DIST << k;

    logic [N-1:0][TW-1:0] cur, sum_d, nxt;

    if (k == 0) begin : g_src0
      assign cur = terms0;
    end else begin : g_srck
      assign cur = g_lyr[k-1].nxt;
    end

    // Pair (2j, 2j+1); an odd trailing term passes through untouched
    always_comb begin
      sum_d = '0;
      for (int j = 0; j < NO; j++) begin
        sum_d[j] = cur[2*j];
        if (2*j + 1 < NI)
          sum_d[j] = cur[2*j] + (cur[(2*j + 1 < NI) ? 2*j + 1 : 0] << SH);
      end
    end

    if (REGISTER_MIDDLE != 0) begin : g_reg
      logic [N-1:0][TW-1:0] sum_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  sum_q <= '0;
        else if (ce) sum_q <= sum_d;
      end
      assign nxt = sum_q;
    end else begin : g_comb
      assign nxt = sum_d;
    end
  end

  logic [N-1:0][TW-1:0] root;
  if (NL == 0) begin : g_root0
    assign root = terms0;
  end else begin : g_rootn
    assign root = g_lyr[NL-1].nxt;
  end

  logic [OUT_BITS-1:0] out_d;
  always_comb out_d = root[0][OUT_BITS-1:0];

  if (REGISTER_OUTPUT != 0) begin : g_oreg
    logic [OUT_BITS-1:0] out_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  out_q <= '0;
      else if (ce) out_q <= out_d;
    end
    assign out = out_q;
  end else begin : g_ocomb
    assign out = out_d;
  end

  // Side-band bit rides a shift register matching the data latency
  if (EXTRA_BIT_USED != 0 && LAT > 0) begin : g_xb
    logic [LAT-1:0] xb_d, xb_q;
    always_comb xb_d = LAT'({xb_q, extra_bit_in});
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  xb_q <= '0;
      else if (ce) xb_q <= xb_d;
    end
    assign extra_bit_out = xb_q[LAT-1];
  end else if (EXTRA_BIT_USED != 0) begin : g_xb_comb
    assign extra_bit_out = extra_bit_in;
  end else begin : g_xb_off
    assign extra_bit_out = 1'b0;
  end

  logic unused_ok;
  assign unused_ok = ^{ce, extra_bit_in, root};

endmodule

// File: tb/tb_adder_tree.sv
// Directed table-driven bench for adder_tree across five parameter sets, plus
// back-to-back streaming and mid-stream reset sequences.
module tb_adder_tree;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic xb_in = 1'b0;
  always #5 clk = ~clk;

`ifdef ADDER_TREE_CE_EN
  logic ena = 1'b1;
`endif

  logic [15:0]  in0 = '0, in1 = '0;
  logic [11:0]  in2 = '0;
  logic [207:0] in3 = '0;
  logic [39:0]  in4 = '0;
  logic [7:0]   out0, out1, out2;
  logic [28:0]  out3;
  logic [15:0]  out4;
  logic         xb0, xb1, xb2, xb3, xb4;

  int n_pass = 0;
  int n_total = 0;

  adder_tree #(.NUM_IN_WORDS(4), .BITS_PER_IN_WORD(4), .OUT_BITS(8), .SIGN_EXT(0),
    .REGISTER_OUTPUT(1), .REGISTER_MIDDLE(1), .SHIFT_DIST(1), .EXTRA_BIT_USED(0)) u0 (
    .clk(clk), .rst_n(rst_n),
`ifdef ADDER_TREE_CE_EN
    .ena(ena),
`endif
    .in_words(in0), .extra_bit_in(xb_in), .extra_bit_out(xb0), .out(out0));

  adder_tree #(.NUM_IN_WORDS(4), .BITS_PER_IN_WORD(4), .OUT_BITS(8), .SIGN_EXT(1),
    .REGISTER_OUTPUT(1), .REGISTER_MIDDLE(1), .SHIFT_DIST(1), .EXTRA_BIT_USED(0)) u1 (
    .clk(clk), .rst_n(rst_n),
`ifdef ADDER_TREE_CE_EN
    .ena(ena),
`endif
    .in_words(in1), .extra_bit_in(xb_in), .extra_bit_out(xb1), .out(out1));

  adder_tree #(.NUM_IN_WORDS(3), .BITS_PER_IN_WORD(4), .OUT_BITS(8), .SIGN_EXT(0),
    .REGISTER_OUTPUT(1), .REGISTER_MIDDLE(1), .SHIFT_DIST(1), .EXTRA_BIT_USED(0)) u2 (
    .clk(clk), .rst_n(rst_n),
`ifdef ADDER_TREE_CE_EN
    .ena(ena),
`endif
    .in_words(in2), .extra_bit_in(xb_in), .extra_bit_out(xb2), .out(out2));

  adder_tree #(.NUM_IN_WORDS(13), .BITS_PER_IN_WORD(16), .OUT_BITS(29), .SIGN_EXT(1),
    .REGISTER_OUTPUT(1), .REGISTER_MIDDLE(1), .SHIFT_DIST(1), .EXTRA_BIT_USED(1)) u3 (
    .clk(clk), .rst_n(rst_n),
`ifdef ADDER_TREE_CE_EN
    .ena(ena),
`endif
    .in_words(in3), .extra_bit_in(xb_in), .extra_bit_out(xb3), .out(out3));

  adder_tree #(.NUM_IN_WORDS(5), .BITS_PER_IN_WORD(8), .OUT_BITS(16), .SIGN_EXT(0),
    .REGISTER_OUTPUT(1), .REGISTER_MIDDLE(0), .SHIFT_DIST(2), .EXTRA_BIT_USED(0)) u4 (
    .clk(clk), .rst_n(rst_n),
`ifdef ADDER_TREE_CE_EN
    .ena(ena),
`endif
    .in_words(in4), .extra_bit_in(xb_in), .extra_bit_out(xb4), .out(out4));

  typedef struct {
    int           dut;
    logic [207:0] bus;
    logic         xb;
    logic [31:0]  exp;
    logic         exp_xb;
    string        name;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Partial products of a signed 16-bit a times a 13-bit two's complement b
  function automatic logic [207:0] mulp(input logic signed [15:0] a, input logic [12:0] b);
    logic [207:0] r;
    r = '0;
    for (int i = 0; i < 12; i++) r[i*16 +: 16] = b[i] ? a : 16'h0;
    r[192 +: 16] = b[12] ? ~a : 16'h0;
    return r;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 3) ? 5 : (d == 4) ? 1 : 3;
  endfunction

  function automatic logic [31:0] out_of(input int d);
    case (d)
      0: return {24'h0, out0};
      1: return {24'h0, out1};
      2: return {24'h0, out2};
      3: return {3'h0, out3};
      default: return {16'h0, out4};
    endcase
  endfunction

  function automatic logic xb_of(input int d);
    case (d)
      0: return xb0;
      1: return xb1;
      2: return xb2;
      3: return xb3;
      default: return xb4;
    endcase
  endfunction

  function automatic vec_t mk(input int d, input logic [207:0] bus, input logic xb,
                              input logic [31:0] e, input logic ex, input string n);
    vec_t v;
    v.dut = d; v.bus = bus; v.xb = xb; v.exp = e; v.exp_xb = ex; v.name = n;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    @(negedge clk);
    xb_in = v.xb;
    case (v.dut)
      0: in0 = v.bus[15:0];
      1: in1 = v.bus[15:0];
      2: in2 = v.bus[11:0];
      3: in3 = v.bus;
      default: in4 = v.bus[39:0];
    endcase
    repeat (lat_of(v.dut)) @(posedge clk);
    #1;
    chk({v.name, "_out"}, out_of(v.dut), v.exp);
    chk({v.name, "_xb"}, {31'h0, xb_of(v.dut)}, {31'h0, v.exp_xb});
  endtask

  logic [15:0] seq_in [6];
  logic [7:0]  seq_exp [6];

  initial begin
    tbl.push_back(mk(0, 208'h1111, 1'b1, 32'h0F, 1'b0, "u0_ones"));
    tbl.push_back(mk(0, 208'hFFFF, 1'b0, 32'hE1, 1'b0, "u0_allf"));
    tbl.push_back(mk(0, 208'hF000, 1'b0, 32'h78, 1'b0, "u0_top"));
    tbl.push_back(mk(0, 208'h0305, 1'b1, 32'h11, 1'b0, "u0_mix"));
    tbl.push_back(mk(1, 208'h000F, 1'b0, 32'hFF, 1'b0, "u1_neg1"));
    tbl.push_back(mk(1, 208'h8000, 1'b0, 32'hC0, 1'b0, "u1_neg8_w3"));
    tbl.push_back(mk(1, 208'h7777, 1'b0, 32'h69, 1'b0, "u1_pos"));
    tbl.push_back(mk(1, 208'h8888, 1'b0, 32'h88, 1'b0, "u1_allneg"));
    tbl.push_back(mk(1, 208'h12F3, 1'b0, 32'h11, 1'b0, "u1_mix"));
    tbl.push_back(mk(2, 208'h753, 1'b0, 32'h29, 1'b0, "u2_357"));
    tbl.push_back(mk(2, 208'hFFF, 1'b1, 32'h69, 1'b0, "u2_allf"));
    tbl.push_back(mk(2, 208'h100, 1'b0, 32'h04, 1'b0, "u2_odd_pass"));
    tbl.push_back(mk(3, mulp(-16'sd3, 13'd5), 1'b0, 32'h1FFFFFF1, 1'b0, "u3_m3x5"));
    tbl.push_back(mk(3, mulp(-16'sd3, 13'h1FFF), 1'b1, 32'h1FFFF003, 1'b1, "u3_m3xm1"));
    tbl.push_back(mk(3, mulp(16'sd7, 13'd3), 1'b0, 32'h15, 1'b0, "u3_7x3"));
    tbl.push_back(mk(3, {208{1'b1}}, 1'b1, 32'h1FFFE001, 1'b1, "u3_allneg"));
    tbl.push_back(mk(4, 208'h01_01_01_01_01, 1'b0, 32'h0155, 1'b0, "u4_ones"));
    tbl.push_back(mk(4, 208'hFF_00_00_00_FF, 1'b0, 32'hFFFF, 1'b0, "u4_ends"));
    tbl.push_back(mk(4, 208'hFF_00_00_00_00, 1'b0, 32'hFF00, 1'b0, "u4_top"));
    tbl.push_back(mk(4, 208'h00_00_01_02_03, 1'b0, 32'h001B, 1'b0, "u4_mix"));
    tbl.push_back(mk(4, 208'hFF_FF_FF_FF_FF, 1'b0, 32'h53AB, 1'b0, "u4_trunc"));

    seq_in = '{16'h0001, 16'h0010, 16'h0100, 16'h1000, 16'h1111, 16'h2222};
    seq_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h0F, 8'h1E};

    // Reset state with non-zero inputs present
    in0 = 16'hFFFF; in1 = 16'h7777; in2 = 12'hFFF; in3 = {208{1'b1}}; in4 = 40'hFF; xb_in = 1'b1;
    #12;
    chk("rst_out0", {24'h0, out0}, 32'h0);
    chk("rst_out3", {3'h0, out3}, 32'h0);
    chk("rst_xb3", {31'h0, xb3}, 32'h0);
    chk("rst_out4", {16'h0, out4}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // Back-to-back stream on u0: one result per cycle after fixed latency 3
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 6) in0 = seq_in[c];
      @(posedge clk);
      #1;
      if (c >= 2) chk($sformatf("stream_%0d", c - 2), {24'h0, out0}, {24'h0, seq_exp[c-2]});
    end

    // Mid-stream asynchronous reset, then exact refill latency
    @(negedge clk);
    in0 = 16'h1111;
    in3 = mulp(-16'sd3, 13'h1FFF);
    xb_in = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("pre_rst_out3", {3'h0, out3}, 32'h1FFFF003);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out0", {24'h0, out0}, 32'h0);
    chk("async_rst_out3", {3'h0, out3}, 32'h0);
    chk("async_rst_xb3", {31'h0, xb3}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("held_rst_out3", {3'h0, out3}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("refill_out0_c%0d", c), {24'h0, out0}, (c >= 3) ? 32'h0F : 32'h0);
      chk($sformatf("refill_out3_c%0d", c), {3'h0, out3}, (c == 5) ? 32'h1FFFF003 : 32'h0);
      chk($sformatf("refill_xb3_c%0d", c), {31'h0, xb3}, (c == 5) ? 32'h1 : 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
